// File: rtl/cnn_image_loader.sv
// Front-end loader for the CNN core: packs a raster pixel stream into image_packed, launches the
// CNN with an active-low convolution_enable pulse and captures its result. Optional LOADER_PIXEL_CHECK_EN.
module cnn_image_loader #(
  parameter int IMAGE_WIDTH       = 12,
  parameter int IMAGE_HEIGHT      = 12,
  parameter int PIXEL_WIDTH       = 2,
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int START_TIMEOUT     = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_loader,
  input  logic [PIXEL_WIDTH-1:0]                          pixel_in,
  input  logic                                            pixel_sof,
  input  logic                                            pixel_valid,
  output logic                                            pixel_ready,
  output logic [PIXEL_WIDTH*IMAGE_WIDTH*IMAGE_HEIGHT-1:0] image_packed,
  output logic                                            convolution_enable,
  input  logic                                            cnn_idle,
  input  logic [OUTPUT_DATA_WIDTH-1:0]                    cnn_output,
  output logic [OUTPUT_DATA_WIDTH-1:0]                    result,
  output logic                                            result_valid,
  output logic                                            timeout_err,
  output logic                                            resync_err
`ifdef LOADER_PIXEL_CHECK_EN
  ,
  output logic                                            pixel_err
`endif
);

  localparam int unsigned N  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    LOAD,
    LAUNCH,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          idx;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   accept;
  logic                   frame_done;
  logic                   start_timeout;
  logic                   capture;
  logic                   resync_hit;
  logic [PIXEL_WIDTH-1:0] pix_store;

`ifdef LOADER_PIXEL_CHECK_EN
  // The most negative code lies outside {-1,0,1}; it is stored as zero and flagged.
  localparam logic [PIXEL_WIDTH-1:0] PIX_ILLEGAL = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};
  logic pix_illegal;

  always_comb begin
    pix_illegal = (pixel_in == PIX_ILLEGAL);
    pix_store   = pix_illegal ? '0 : pixel_in;
  end
`else
  always_comb begin
    pix_store = pixel_in;
  end
`endif

  // pixel_ready is high exactly while in LOAD, so accept implies LOAD.
  always_comb begin
    accept        = pixel_valid && pixel_ready;
    idx           = pixel_sof ? '0 : count_q;
    frame_done    = accept && (idx == CW'(N - 1));
    resync_hit    = accept && pixel_sof && (count_q != '0);
    state_d       = state_q;
    count_d       = count_q;
    timer_d       = timer_q;
    start_timeout = 1'b0;
    capture       = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (frame_done) begin
            count_d = '0;
            state_d = LAUNCH;
          end else begin
            count_d = idx + 1'b1;
          end
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (!cnn_idle) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          start_timeout = 1'b1;
          state_d       = LOAD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (cnn_idle) begin
          capture = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Handshake and enable are registered from the next state so both line up with the state change.
  always_ff @(posedge clk or negedge rst_loader) begin
    if (!rst_loader) begin
      state_q            <= LOAD;
      count_q            <= '0;
      timer_q            <= '0;
      pixel_ready        <= 1'b0;
      convolution_enable <= 1'b1;
      result             <= '0;
      result_valid       <= 1'b0;
      timeout_err        <= 1'b0;
      resync_err         <= 1'b0;
    end else begin
      state_q            <= state_d;
      count_q            <= count_d;
      timer_q            <= timer_d;
      pixel_ready        <= (state_d == LOAD);
      convolution_enable <= (state_d != LAUNCH);
      result_valid       <= capture;
      if (capture) result <= cnn_output;
      if (start_timeout) timeout_err <= 1'b1;
      if (resync_hit) resync_err <= 1'b1;
    end
  end

  // Pixel k lands at the k-th field from the MSB end; untouched fields keep their old value.
  always_ff @(posedge clk or negedge rst_loader) begin
    if (!rst_loader) begin
      image_packed <= '0;
    end else if (accept) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (idx == CW'(k)) image_packed[(N-k)*PIXEL_WIDTH-1 -: PIXEL_WIDTH] <= pix_store;
      end
    end
  end

`ifdef LOADER_PIXEL_CHECK_EN
  always_ff @(posedge clk or negedge rst_loader) begin
    if (!rst_loader) begin
      pixel_err <= 1'b0;
    end else if (accept && pix_illegal) begin
      pixel_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cnn_image_loader.sv
// Self-checking bench for cnn_image_loader: table of frame/CNN-response cases, a behavioural CNN
// and an array-based image reference; also covers async reset and the LOADER_PIXEL_CHECK_EN build.
module tb_cnn_image_loader;

  localparam int W   = 12;
  localparam int H   = 12;
  localparam int PW  = 2;
  localparam int ODW = 32;
  localparam int TO  = 8;
  localparam int N   = W * H;
  localparam int IB  = PW * N;
  localparam int CLK = 10;

  logic           clk = 1'b0;
  logic           rst_loader = 1'b0;
  logic [PW-1:0]  pixel_in = '0;
  logic           pixel_sof = 1'b0;
  logic           pixel_valid = 1'b0;
  logic           pixel_ready;
  logic [IB-1:0]  image_packed;
  logic           convolution_enable;
  logic           cnn_idle = 1'b1;
  logic [ODW-1:0] cnn_output = '0;
  logic [ODW-1:0] result;
  logic           result_valid;
  logic           timeout_err;
  logic           resync_err;
`ifdef LOADER_PIXEL_CHECK_EN
  logic           pixel_err;
`endif

  cnn_image_loader #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_WIDTH(PW),
    .OUTPUT_DATA_WIDTH(ODW), .START_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_loader(rst_loader), .pixel_in(pixel_in), .pixel_sof(pixel_sof),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .image_packed(image_packed),
    .convolution_enable(convolution_enable), .cnn_idle(cnn_idle), .cnn_output(cnn_output),
    .result(result), .result_valid(result_valid), .timeout_err(timeout_err),
    .resync_err(resync_err)
`ifdef LOADER_PIXEL_CHECK_EN
    , .pixel_err(pixel_err)
`endif
  );

  always #(CLK/2) clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [IB-1:0] act, input logic [IB-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference image: plain array of stored pixel values indexed by raster position.
  logic [PW-1:0] ref_img [N];
  int            ref_cnt = 0;
  bit            ref_perr = 0;
  time           last_pixel_t = 0;

  function automatic logic [IB-1:0] ref_packed();
    logic [IB-1:0] v = '0;
    for (int k = 0; k < N; k++) v = (v << PW) | IB'(ref_img[k]);
    return v;
  endfunction

  function automatic bit model_accept(input logic [PW-1:0] px, input bit sof);
    int idx = sof ? 0 : ref_cnt;
    logic [PW-1:0] st = px;
`ifdef LOADER_PIXEL_CHECK_EN
    if (px == 2'b10) begin
      st = '0;
      ref_perr = 1;
    end
`endif
    ref_img[idx] = st;
    ref_cnt = idx + 1;
    if (ref_cnt == N) begin
      ref_cnt = 0;
      return 1;
    end
    return 0;
  endfunction

  // Behavioural CNN plus event recorder; the main process only reads what this block records.
  bit          cnn_stuck = 0;
  int          cnn_delay = 20;
  logic [31:0] cnn_value = '0;
  int          abort_req = 0;
  int          abort_seen = 0;
  int          cnn_busy = 0;
  int          launch_cnt = 0;
  int          rv_cnt = 0;
  int          low_run = 0;
  int          max_low_run = 0;
  time         last_launch_t = 0;
  time         last_rv_t = 0;
  time         idle_rise_t = 0;

  always @(negedge clk) begin
    if (!convolution_enable) begin
      launch_cnt++;
      last_launch_t = $time;
      low_run++;
      if (low_run > max_low_run) max_low_run = low_run;
    end else begin
      low_run = 0;
    end
    if (result_valid) begin
      rv_cnt++;
      last_rv_t = $time;
    end
    if (abort_req != abort_seen) begin
      abort_seen = abort_req;
      cnn_busy = 0;
      cnn_idle = 1'b1;
    end else if (!convolution_enable) begin
      if (!cnn_stuck) begin
        cnn_idle = 1'b0;
        cnn_output = $urandom;
        cnn_busy = cnn_delay + 1;
      end
    end else if (cnn_busy > 0) begin
      cnn_busy--;
      if (cnn_busy == 0) begin
        cnn_idle = 1'b1;
        cnn_output = cnn_value;
        idle_rise_t = $time;
      end
    end
  end

  typedef struct {
    bit          first_sof;
    bit          randv;
    int          resync_at;
    bit          stuck;
    int          delay;
    logic [31:0] value;
    int          exp_rv;
    bit          exp_to;
    bit          exp_rs;
    logic [31:0] exp_result;
  } entry_t;

  entry_t tbl [4];

  task automatic do_reset();
    #2 rst_loader = 1'b0;
    abort_req++;
    #1;
    ref_cnt = 0;
    ref_perr = 0;
    for (int k = 0; k < N; k++) ref_img[k] = '0;
    check("rst_pixel_ready", pixel_ready, 0);
    check("rst_conv_enable", convolution_enable, 1);
    check("rst_image", image_packed, ref_packed());
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_resync_err", resync_err, 0);
`ifdef LOADER_PIXEL_CHECK_EN
    check("rst_pixel_err", pixel_err, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_loader = 1'b1;
    @(negedge clk);
    check("ready_after_reset", pixel_ready, 1);
  endtask

  task automatic push(input logic [PW-1:0] px, input bit sof, input bit randv, output bit done);
    bit acc = 0;
    int guard = 0;
    done = 0;
    while (!acc && guard < 300) begin
      if (randv && $urandom_range(0, 1) == 0) begin
        pixel_valid = 1'b0;
      end else begin
        pixel_valid = 1'b1;
        pixel_in = px;
        pixel_sof = sof;
        if (pixel_ready) begin
          acc = 1;
          done = model_accept(px, sof);
          if (done) last_pixel_t = $time;
        end
      end
      @(negedge clk);
      guard++;
    end
    pixel_valid = 1'b0;
    pixel_sof = 1'b0;
    if (!acc) check("pixel_accept_wait", 0, 1);
  endtask

  task automatic run_entry(input entry_t t);
    bit done = 0;
    int l0 = launch_cnt;
    int r0 = rv_cnt;
    int g = 0;
    cnn_stuck = t.stuck;
    cnn_delay = t.delay;
    cnn_value = t.value;
    for (int i = 0; i < t.resync_at; i++)
      push(PW'($urandom_range(0, 3)), (i == 0) && t.first_sof, t.randv, done);
    for (int i = 0; i < N; i++)
      push(PW'($urandom_range(0, 3)), (i == 0) && (t.first_sof || t.resync_at > 0), t.randv, done);
    check("frame_complete", done, 1);
    check("ready_drop", pixel_ready, 0);
    check("image_packed", image_packed, ref_packed());
    check("pixel0_msb", image_packed[IB-1 -: PW], ref_img[0]);
    check("pixel_last_lsb", image_packed[PW-1:0], ref_img[N-1]);
    if (t.stuck) begin
      repeat (8) @(negedge clk);
      check("busy_before_timeout", pixel_ready, 0);
      @(negedge clk);
      check("timeout_set", timeout_err, 1);
      check("load_after_timeout", pixel_ready, 1);
    end else begin
      while (!result_valid && g < 200) begin
        @(negedge clk);
        g++;
      end
      check("result_valid_seen", result_valid, 1);
      check("result_at_strobe", result, t.exp_result);
      check("image_stable", image_packed, ref_packed());
      @(negedge clk);
      check("result_valid_single", result_valid, 0);
      check("ready_after_result", pixel_ready, 1);
    end
    repeat (2) @(negedge clk);
    check("launch_count", launch_cnt - l0, 1);
    check("launch_latency", last_launch_t, last_pixel_t + CLK);
    check("result_valid_count", rv_cnt - r0, t.exp_rv);
    if (t.exp_rv > 0) check("result_valid_latency", last_rv_t, idle_rise_t + CLK);
    check("timeout_err", timeout_err, t.exp_to);
    check("resync_err", resync_err, t.exp_rs);
    check("result_hold", result, t.exp_result);
  endtask

  initial begin
    bit done;
    tbl[0] = '{1, 0, 0,  0, 20, 32'd1234,      1, 0, 0, 32'd1234};
    tbl[1] = '{1, 0, 0,  1, 0,  32'd0,         0, 1, 0, 32'd1234};
    tbl[2] = '{0, 1, 0,  0, 5,  32'hDEADBEEF,  1, 1, 0, 32'hDEADBEEF};
    tbl[3] = '{1, 0, 50, 0, 3,  32'd7,         1, 1, 1, 32'd7};

    @(negedge clk);
    do_reset();
    for (int e = 0; e < 4; e++) run_entry(tbl[e]);

    // Reset 70 pixels into a frame, then a clean frame.
    for (int i = 0; i < 70; i++) push(PW'($urandom_range(0, 3)), i == 0, 0, done);
    do_reset();
    run_entry('{1, 0, 0, 0, 20, 32'd55, 1, 0, 0, 32'd55});

    // Reset while the CNN is busy, then a clean frame with gapped input.
    cnn_stuck = 0;
    cnn_delay = 20;
    cnn_value = 32'h0BAD_0BAD;
    for (int i = 0; i < N; i++) push(PW'($urandom_range(0, 3)), i == 0, 0, done);
    repeat (6) @(negedge clk);
    check("busy_in_wait_done", pixel_ready, 0);
    do_reset();
    run_entry('{1, 1, 0, 0, 8, 32'hA5A5_0001, 1, 0, 0, 32'hA5A5_0001});

`ifdef LOADER_PIXEL_CHECK_EN
    cnn_delay = 4;
    for (int i = 0; i < N; i++)
      push((i == 5) ? 2'b10 : 2'b01, i == 0, 0, done);
    check("illegal_pixel_zeroed", image_packed[(N-5)*PW-1 -: PW], 0);
    check("pixel_err_set", pixel_err, ref_perr);
    check("pixel_err_image", image_packed, ref_packed());
    repeat (20) @(negedge clk);
`endif

    check("enable_pulse_width", max_low_run, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
